// File: rtl/password_entry.sv
// -----------------------------------------------------------------------------
// password_entry
//
// Keypad-to-display sequencing stage. Collects up to four digits from the
// keypad scanner into a left-aligned BCD entry buffer. On ENTER it compares
// the buffer with PASSWORD. The result is shown on the LCD controller through
// sel_msg for a fixed time. Consecutive failures are counted, and MAX_TRIES of
// them in a row lock the keypad for LOCK_CYCLES.
//
// Optional build macro:
//   MASK_DISPLAY_EN  defined   -> char_out is '*' (8'h2A) for every digit
//                    undefined -> char_out is the ASCII code of the digit
//
// Parameters:
//   PASSWORD     four BCD digits; the first-entered digit is compared to [15:12]
//   MAX_TRIES    consecutive wrong attempts that lock the keypad (1..3)
//   HOLD_CYCLES  clk cycles the GRANTED/DENIED message is held (>= 1)
//   LOCK_CYCLES  clk cycles the LOCKED state lasts (>= 1)
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   digito        key code: 0x0-0x9 digit, 0xC CLEAR, 0xE ENTER, others ignored
//   key_detected  high while a key is pressed; digito is valid while high
//   sel_msg       00 ENTRY, 01 GRANTED, 10 DENIED, 11 LOCKED
//   code          entered digits, left-aligned BCD, unused nibbles 0
//   count         number of digits entered (0-4)
//   char_out      ASCII character of the last accepted digit
//   char_valid    one-cycle strobe accompanying char_out
//   unlocked      high throughout GRANTED
//   fails         consecutive failed attempts
// -----------------------------------------------------------------------------
module password_entry #(
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned LOCK_CYCLES = 250_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digito,
    input  logic        key_detected,
    output logic [1:0]  sel_msg,
    output logic [15:0] code,
    output logic [2:0]  count,
    output logic [7:0]  char_out,
    output logic        char_valid,
    output logic        unlocked,
    output logic [1:0]  fails
);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_GRANTED = 3'd2,
        ST_DENIED  = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    localparam logic [3:0]  KEY_CLEAR   = 4'hC;
    localparam logic [3:0]  KEY_ENTER   = 4'hE;
    localparam logic [1:0]  MSG_ENTRY   = 2'b00;
    localparam logic [1:0]  MSG_GRANTED = 2'b01;
    localparam logic [1:0]  MSG_DENIED  = 2'b10;
    localparam logic [1:0]  MSG_LOCKED  = 2'b11;
    localparam logic [1:0]  FAILS_MAX   = 2'(MAX_TRIES);
    localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 32'd1);
    localparam logic [31:0] LOCK_LAST   = 32'(LOCK_CYCLES - 32'd1);

    // Write digit d into nibble slot pos; slot 0 is the leftmost nibble [15:12].
    function automatic logic [15:0] put_nibble(input logic [15:0] c,
                                               input logic [2:0]  pos,
                                               input logic [3:0]  d);
        logic [15:0] r;
        r = c;
        case (pos)
            3'd0:    r[15:12] = d;
            3'd1:    r[11:8]  = d;
            3'd2:    r[7:4]   = d;
            3'd3:    r[3:0]   = d;
            default: r        = c;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        key_q, key_d;
    logic [15:0] code_q, code_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  char_out_q, char_out_d;
    logic        char_valid_q, char_valid_d;
    logic [1:0]  sel_msg_q, sel_msg_d;
    logic        unlocked_q, unlocked_d;
    logic [1:0]  fails_q, fails_d;

    logic        key_ev_s;
    logic [1:0]  fails_inc_s;
    logic [7:0]  digit_char_s;

    // Displayed character for an accepted digit.
`ifdef MASK_DISPLAY_EN
    assign digit_char_s = 8'h2A;
`else
    assign digit_char_s = 8'h30 + {4'h0, digito};
`endif

    // Rising edge of key_detected: exactly one event per press.
    assign key_ev_s    = key_detected & ~key_q;
    // Failure count saturates at MAX_TRIES.
    assign fails_inc_s = (fails_q == FAILS_MAX) ? fails_q : (fails_q + 2'd1);

    // Next-state and next-output logic for the entry sequencer.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        key_d        = key_detected;
        code_d       = code_q;
        count_d      = count_q;
        char_out_d   = char_out_q;
        char_valid_d = 1'b0;
        sel_msg_d    = sel_msg_q;
        unlocked_d   = unlocked_q;
        fails_d      = fails_q;

        case (state_q)
            ST_ENTRY: begin
                timer_d = 32'd0;
                if (key_ev_s) begin
                    if (digito <= 4'd9) begin
                        if (count_q < 3'd4) begin
                            code_d       = put_nibble(code_q, count_q, digito);
                            count_d      = count_q + 3'd1;
                            char_out_d   = digit_char_s;
                            char_valid_d = 1'b1;
                        end else begin
                            count_d = count_q;
                        end
                    end else if (digito == KEY_CLEAR) begin
                        code_d  = 16'h0000;
                        count_d = 3'd0;
                    end else if (digito == KEY_ENTER) begin
                        if (count_q == 3'd4) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_ENTRY;
                        end
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else begin
                    state_d = ST_ENTRY;
                end
            end

            ST_CHECK: begin
                timer_d = 32'd0;
                if (code_q == PASSWORD) begin
                    state_d    = ST_GRANTED;
                    sel_msg_d  = MSG_GRANTED;
                    unlocked_d = 1'b1;
                    fails_d    = 2'd0;
                end else begin
                    fails_d = fails_inc_s;
                    if (fails_inc_s == FAILS_MAX) begin
                        state_d   = ST_LOCKED;
                        sel_msg_d = MSG_LOCKED;
                    end else begin
                        state_d   = ST_DENIED;
                        sel_msg_d = MSG_DENIED;
                    end
                end
            end

            ST_GRANTED, ST_DENIED: begin
                // The message is shown for exactly HOLD_CYCLES cycles.
                if (timer_q == HOLD_LAST) begin
                    state_d    = ST_ENTRY;
                    timer_d    = 32'd0;
                    sel_msg_d  = MSG_ENTRY;
                    unlocked_d = 1'b0;
                    code_d     = 16'h0000;
                    count_d    = 3'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            ST_LOCKED: begin
                if (timer_q == LOCK_LAST) begin
                    state_d   = ST_ENTRY;
                    timer_d   = 32'd0;
                    sel_msg_d = MSG_ENTRY;
                    fails_d   = 2'd0;
                    code_d    = 16'h0000;
                    count_d   = 3'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            default: begin
                state_d    = ST_ENTRY;
                timer_d    = 32'd0;
                sel_msg_d  = MSG_ENTRY;
                unlocked_d = 1'b0;
                code_d     = 16'h0000;
                count_d    = 3'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ENTRY;
            timer_q      <= 32'd0;
            key_q        <= 1'b0;
            code_q       <= 16'h0000;
            count_q      <= 3'd0;
            char_out_q   <= 8'h00;
            char_valid_q <= 1'b0;
            sel_msg_q    <= MSG_ENTRY;
            unlocked_q   <= 1'b0;
            fails_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            key_q        <= key_d;
            code_q       <= code_d;
            count_q      <= count_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            sel_msg_q    <= sel_msg_d;
            unlocked_q   <= unlocked_d;
            fails_q      <= fails_d;
        end
    end

    assign sel_msg    = sel_msg_q;
    assign code       = code_q;
    assign count      = count_q;
    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign unlocked   = unlocked_q;
    assign fails      = fails_q;

endmodule

// File: tb/tb_password_entry.sv
// -----------------------------------------------------------------------------
// tb_password_entry
//
// Scoreboard bench for password_entry. The stimulus process drives key
// presses. A behavioural model (a digit queue plus a failure counter) pushes
// the expected character strobes and message changes into queues. An
// independent monitor samples the DUT on the falling clock edge. It pops and
// compares an expected entry whenever the DUT strobes a character or changes
// sel_msg. Quiet-state snapshots are requested through a third queue.
// -----------------------------------------------------------------------------
module tb_password_entry;

    localparam logic [15:0] PW   = 16'h1234;
    localparam int          MAXT = 3;
    localparam int          HOLD = 24;
    localparam int          LOCK = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digito;
    logic        key_detected;
    logic [1:0]  sel_msg;
    logic [15:0] code;
    logic [2:0]  count;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        unlocked;
    logic [1:0]  fails;

    password_entry #(
        .PASSWORD(PW), .MAX_TRIES(MAXT), .HOLD_CYCLES(HOLD), .LOCK_CYCLES(LOCK)
    ) dut (
        .clk(clk), .rst(rst), .digito(digito), .key_detected(key_detected),
        .sel_msg(sel_msg), .code(code), .count(count), .char_out(char_out),
        .char_valid(char_valid), .unlocked(unlocked), .fails(fails)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ch;
        logic [2:0]  cnt;
        logic [15:0] cd;
    } chr_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic        unl;
        logic [1:0]  fl;
        logic [15:0] cd;
        logic [2:0]  cnt;
        int          len;   // expected length of the message just ended, -1 = skip
    } msg_t;

    typedef struct packed {
        logic [1:0]  fl;
        logic [15:0] cd;
        logic [2:0]  cnt;
        logic        chk_char;
        logic [7:0]  ch;
    } idle_t;

    chr_t  chr_q[$];
    msg_t  msg_q[$];
    idle_t idle_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en     = 1'b0;
    logic final_req  = 1'b0;
    logic final_done = 1'b0;

    // Reference model state.
    int m_digs[$];
    int m_fails = 0;
    int pending = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_code();
        int v;
        v = 0;
        for (int i = 0; i < m_digs.size(); i++) v += m_digs[i] * (16 ** (3 - i));
        return v[15:0];
    endfunction

    function automatic logic [7:0] model_char(input int d);
`ifdef MASK_DISPLAY_EN
        return 8'h2A;
`else
        return 8'(48 + d);
`endif
    endfunction

    // Apply the keypad rules to one accepted key event.
    task automatic model_key(input int k);
        chr_t  c;
        msg_t  m;
        logic [15:0] v;
        if (k <= 9) begin
            if (m_digs.size() < 4) begin
                m_digs.push_back(k);
                c.ch = model_char(k); c.cnt = 3'(m_digs.size()); c.cd = model_code();
                chr_q.push_back(c);
            end
        end else if (k == 12) begin
            m_digs.delete();
        end else if (k == 14 && m_digs.size() == 4) begin
            v = model_code();
            if (v == PW) begin
                m_fails = 0;
                m = '{sel: 2'b01, unl: 1'b1, fl: 2'd0, cd: v, cnt: 3'd4, len: -1};
                msg_q.push_back(m);
                m = '{sel: 2'b00, unl: 1'b0, fl: 2'd0, cd: 16'h0, cnt: 3'd0, len: HOLD};
                msg_q.push_back(m);
                pending = HOLD + 4;
            end else begin
                m_fails = m_fails + 1;
                if (m_fails == MAXT) begin
                    m = '{sel: 2'b11, unl: 1'b0, fl: 2'(MAXT), cd: v, cnt: 3'd4, len: -1};
                    msg_q.push_back(m);
                    m_fails = 0;
                    m = '{sel: 2'b00, unl: 1'b0, fl: 2'd0, cd: 16'h0, cnt: 3'd0, len: LOCK};
                    msg_q.push_back(m);
                    pending = LOCK + 4;
                end else begin
                    m = '{sel: 2'b10, unl: 1'b0, fl: 2'(m_fails), cd: v, cnt: 3'd4, len: -1};
                    msg_q.push_back(m);
                    m = '{sel: 2'b00, unl: 1'b0, fl: 2'(m_fails), cd: 16'h0, cnt: 3'd0, len: HOLD};
                    msg_q.push_back(m);
                    pending = HOLD + 4;
                end
            end
            m_digs.delete();
        end
    endtask

    task automatic press(input int k, input int hold, input int gap);
        @(posedge clk); #1;
        digito = 4'(k);
        key_detected = 1'b1;
        model_key(k);
        repeat (hold) @(posedge clk);
        #1;
        key_detected = 1'b0;
        digito = 4'($urandom_range(0, 15));
        repeat (gap) @(posedge clk);
    endtask

    // Wait out a message, pressing a key in its middle that must be ignored.
    task automatic settle();
        if (pending > 0) begin
            repeat (3) @(posedge clk);
            #1;
            digito = 4'($urandom_range(0, 15));
            key_detected = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            key_detected = 1'b0;
            repeat (pending) @(posedge clk);
            pending = 0;
        end
    endtask

    task automatic idle_check();
        idle_t s;
        @(posedge clk); #1;
        s = '{fl: 2'(m_fails), cd: model_code(), cnt: 3'(m_digs.size()), chk_char: 1'b0, ch: 8'h00};
        idle_q.push_back(s);
        @(posedge clk);
    endtask

    // Monitor: compares DUT outputs against the expectation queues.
    initial begin : monitor
        logic [1:0] prev_sel;
        int         run_len;
        chr_t       c;
        msg_t       m;
        idle_t      s;
        prev_sel = 2'b00;
        run_len  = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (idle_q.size() > 0) begin
                    s = idle_q.pop_front();
                    chk("idle_sel", 32'(sel_msg), 32'd0);
                    chk("idle_fails", 32'(fails), 32'(s.fl));
                    chk("idle_code", 32'(code), 32'(s.cd));
                    chk("idle_count", 32'(count), 32'(s.cnt));
                    chk("idle_char_valid", 32'(char_valid), 32'd0);
                    if (s.chk_char) chk("idle_char_out", 32'(char_out), 32'(s.ch));
                end
                if (char_valid === 1'b1) begin
                    if (chr_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL char_strobe: unexpected strobe char_out=%0h count=%0d", char_out, count);
                    end else begin
                        c = chr_q.pop_front();
                        chk("char_out", 32'(char_out), 32'(c.ch));
                        chk("char_count", 32'(count), 32'(c.cnt));
                        chk("char_code", 32'(code), 32'(c.cd));
                    end
                end
                chk("unlocked_vs_sel", 32'(unlocked), 32'(sel_msg == 2'b01));
                if (sel_msg !== prev_sel) begin
                    if (msg_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL msg_change: unexpected sel_msg=%b (was %b)", sel_msg, prev_sel);
                    end else begin
                        m = msg_q.pop_front();
                        chk("msg_sel", 32'(sel_msg), 32'(m.sel));
                        chk("msg_unlocked", 32'(unlocked), 32'(m.unl));
                        chk("msg_fails", 32'(fails), 32'(m.fl));
                        chk("msg_code", 32'(code), 32'(m.cd));
                        chk("msg_count", 32'(count), 32'(m.cnt));
                        if (m.len >= 0) chk("msg_len", 32'(run_len), 32'(m.len));
                    end
                    run_len = 1;
                end else begin
                    run_len++;
                end
                prev_sel = sel_msg;
            end
            if (final_req && !final_done) begin
                chk("chr_leftover", 32'(chr_q.size()), 32'd0);
                chk("msg_leftover", 32'(msg_q.size()), 32'd0);
                chk("idle_leftover", 32'(idle_q.size()), 32'd0);
                final_done = 1'b1;
            end
        end
    end

    // Stimulus: directed scenarios, then randomized key traffic.
    initial begin : stimulus
        idle_t s;
        msg_t  m;
        int    r;
        int    k;
        int    others[4];
        others = '{10, 11, 13, 15};
        rst = 1'b1;
        digito = 4'h0;
        key_detected = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        s = '{fl: 2'd0, cd: 16'h0, cnt: 3'd0, chk_char: 1'b1, ch: 8'h00};
        idle_q.push_back(s);
        @(posedge clk);

        // Correct password.
        for (int i = 1; i <= 4; i++) press(i, 5, 2);
        press(14, 5, 2); settle();
        idle_check();

        // Three wrong attempts: denied, denied, locked.
        for (int a = 0; a < 3; a++) begin
            for (int i = 5; i <= 8; i++) press(i, 5, 2);
            press(14, 5, 2); settle();
            idle_check();
        end

        // Short ENTER ignored, CLEAR, fifth digit ignored, other code ignored.
        press(9, 5, 2); press(9, 5, 2); press(14, 5, 2); idle_check();
        press(12, 5, 2); idle_check();
        for (int i = 1; i <= 5; i++) press(i, 5, 2);
        press(10, 3, 2); idle_check();
        press(12, 5, 2);

        // Long hold produces one event.
        press(3, 1000, 2); idle_check();
        press(12, 3, 2);

        // Reset in the middle of GRANTED.
        for (int i = 1; i <= 4; i++) press(i, 3, 1);
        press(14, 2, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        msg_q.delete();
        m = '{sel: 2'b00, unl: 1'b0, fl: 2'd0, cd: 16'h0, cnt: 3'd0, len: -1};
        msg_q.push_back(m);
        m_digs.delete(); m_fails = 0; pending = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        s = '{fl: 2'd0, cd: 16'h0, cnt: 3'd0, chk_char: 1'b1, ch: 8'h00};
        idle_q.push_back(s);
        repeat (3) @(posedge clk);

        // Randomized key traffic.
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                for (int i = 1; i <= 4; i++) press(i, $urandom_range(1, 6), $urandom_range(0, 3));
            end else begin
                if (r < 55)      k = $urandom_range(0, 9);
                else if (r < 72) k = 14;
                else if (r < 82) k = 12;
                else             k = others[$urandom_range(0, 3)];
                press(k, $urandom_range(1, 6), $urandom_range(0, 3));
                settle();
            end
            if (it % 10 == 9) idle_check();
        end

        idle_check();
        repeat (3) @(posedge clk);
        final_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/password_entry.md
Name: password_entry

Overview:
- Keypad-to-display sequencing stage; sits directly downstream of the keypad scanner (`teclado`) and upstream of the LCD1602 controller.
- Turns scanner key codes into a 4-digit entry buffer, checks it against a stored password on ENTER, and tracks failed attempts with lockout.
- Drives the controller's message select, plus one ASCII character strobe per accepted digit.

Parameters:
- PASSWORD, 16'h1234, four BCD digits; first-entered digit compared to [15:12].
- MAX_TRIES, 3, consecutive wrong attempts that trigger LOCKED.
- HOLD_CYCLES, 50_000_000, clk cycles GRANTED/DENIED message is held.
- LOCK_CYCLES, 250_000_000, clk cycles LOCKED lasts.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- digito  in  4  key code from scanner: 0x0-0x9 digits, 0xC CLEAR, 0xE ENTER, others ignored.
- key_detected  in  1  high while a key is pressed; digito valid while high.
- sel_msg  out  2  00 ENTRY, 01 GRANTED, 10 DENIED, 11 LOCKED.
- code  out  16  entered digits, left-aligned BCD; unused nibbles 0.
- count  out  3  digits entered, 0-4.
- char_out  out  8  ASCII of last accepted digit.
- char_valid  out  1  one-cycle strobe with char_out.
- unlocked  out  1  high throughout GRANTED.
- fails  out  2  consecutive failed attempts.

Behaviour:
- Reset (sampled on clk rising edge while rst=1):
  - State ENTRY; all outputs 0.
  - Timer 0, key_q 0.
  - rst overrides everything, including mid-hold and mid-lock.
- Key event:
  - key_q registers key_detected.
  - ev = key_detected & ~key_q: one event per press regardless of hold length.
  - digito is sampled in the ev cycle; effects are visible on the next clk edge (latency 1).
- ENTRY:
  - Digit with count<4: stored at nibble position count (first digit → [15:12]); count+1; char_valid=1 for one cycle.
  - Digit with count=4: ignored, no strobe.
  - CLEAR: code=0, count=0, no strobe.
  - ENTER with count<4: ignored.
  - ENTER with count=4: go to CHECK.
  - Other codes: ignored.
- CHECK (1 cycle):
  - code==PASSWORD: go to GRANTED; fails=0.
  - Otherwise fails+1. If the new value equals MAX_TRIES, go to LOCKED; else go to DENIED.
- GRANTED / DENIED:
  - sel_msg 01 / 10; unlocked=1 only in GRANTED.
  - Timer counts HOLD_CYCLES.
  - Then go to ENTRY with code=0, count=0.
  - Key events ignored.
- LOCKED:
  - sel_msg=11; key events ignored; timer counts LOCK_CYCLES.
  - Then go to ENTRY; fails=0, code=0, count=0.
- Timer:
  - Cleared on each state entry.
  - Exit occurs on the cycle the timer reaches (param−1); no wrap.
- Key held across a state return to ENTRY: produces no event, because key_q is already 1.
- fails saturates at MAX_TRIES and never wraps.

Optional Feature:
- Macro: MASK_DISPLAY_EN.
- Defined: char_out = 8'h2A ('*') for every accepted digit.
- Undefined: char_out = 8'h30 + digit.
- Strobe timing is identical in both cases.

Test Plan:
- Press 1,2,3,4 then ENTER (each press held 5 cycles) → count 1..4; char_out 31,32,33,34; code=16'h1234; sel_msg=01 and unlocked=1 for HOLD_CYCLES; then sel_msg=00, count=0.
- Press 5,6,7,8, ENTER → sel_msg=10, fails=1; after hold, sel_msg=00. Repeat twice more → third attempt gives sel_msg=11 for LOCK_CYCLES; keys during lock change nothing; then fails=0.
- Press 9,9 then ENTER → ignored, sel_msg stays 00. Then CLEAR → count=0, code=0. Fifth digit after four → count stays 4, no strobe.
- key_detected held 1000 cycles with digito=3 → exactly one char_valid pulse; count=1.
- rst asserted for 1 cycle mid-GRANTED (small HOLD_CYCLES) → all outputs 0, state ENTRY on the next cycle.
- With MASK_DISPLAY_EN defined, press 7 → char_out=8'h2A with a single strobe.
